// File: rtl/spi_master.sv
// Single-byte SPI mode-0 initiator: one byte out on sdout and one byte in from sdin per start pulse.
// sck is a registered divide of clk; hold_ss keeps ss low between bytes for bursts.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mlb,
  input  logic [7:0] tdata,
  input  logic       hold_ss,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sck,
  output logic       ss,
  output logic       sdout,
  input  logic       sdin
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

  state_t        state, state_n;
  logic [DW-1:0] div, div_n;
  logic [3:0]    bitcnt, bitcnt_n, nxt;
  logic [7:0]    tx, tx_n, rx, rx_n, rx_sh, rdata_n;
  logic          msb, msb_n, busy_n, done_n, sck_n, ss_n, sdout_n;
  logic          expire;
  logic [2:0]    idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      div    <= '0;
      bitcnt <= 4'd0;
      tx     <= 8'h00;
      rx     <= 8'h00;
      msb    <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      rdata  <= 8'h00;
      sck    <= 1'b0;
      ss     <= 1'b1;
      sdout  <= 1'b1;
    end else begin
      state  <= state_n;
      div    <= div_n;
      bitcnt <= bitcnt_n;
      tx     <= tx_n;
      rx     <= rx_n;
      msb    <= msb_n;
      busy   <= busy_n;
      done   <= done_n;
      rdata  <= rdata_n;
      sck    <= sck_n;
      ss     <= ss_n;
      sdout  <= sdout_n;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    tx_n     = tx;
    rx_n     = rx;
    msb_n    = msb;
    busy_n   = busy;
    done_n   = 1'b0;
    rdata_n  = rdata;
    sck_n    = sck;
    ss_n     = ss;
    sdout_n  = sdout;
    expire   = (div == '0);
    div_n    = expire ? div : div - DW'(1);
    nxt      = bitcnt + 4'd1;
    // bit position of the next outgoing bit, counted in transmit order
    idx      = msb ? (3'd7 - nxt[2:0]) : nxt[2:0];
    rx_sh    = msb ? {rx[6:0], sdin} : {sdin, rx[7:1]};

    case (state)
      IDLE: begin
        if (start) begin
          tx_n     = tdata;
          msb_n    = mlb;
          busy_n   = 1'b1;
          ss_n     = 1'b0;
          sdout_n  = mlb ? tdata[7] : tdata[0];
          bitcnt_n = 4'd0;
          div_n    = RELOAD;
          state_n  = SETUP;
        end else if (!ss && !hold_ss) begin
          ss_n = 1'b1;
        end
      end
      SETUP, LOW: begin
        if (expire) begin
          sck_n   = 1'b1;
          rx_n    = rx_sh;
          div_n   = RELOAD;
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (expire) begin
          sck_n    = 1'b0;
          bitcnt_n = nxt;
          div_n    = RELOAD;
          if (nxt < 4'd8) begin
            sdout_n = tx[idx];
            state_n = LOW;
          end else begin
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (expire) begin
          rdata_n = rx;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          sdout_n = 1'b1;
          ss_n    = ~hold_ss;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
